latency_rd_resp: RTL and testbench
==================================

Name: latency_rd_resp

Overview:
- Request/response front end that sits directly upstream of one port (port A) of the latency RAM top and drives its i_ena/i_wea/i_addra/i_dina.
- Accepts valid/ready read and write requests and tracks each read through a RD_LATENCY-deep tag pipe.
- Captures the returning i_douta into a response FIFO and presents it on a valid/ready response interface.
- Credit accounting guarantees that read data returning from the RAM is never dropped.

Parameters:
- DATA_WIDTH, 8, data bus width.
- MEM_DEPTH, 16, RAM depth; ADDR_WIDTH = $clog2(MEM_DEPTH).
- RD_LATENCY, 2, RAM read latency in clka cycles; legal range 1..16.
- FIFO_DEPTH, 4, response FIFO entries; power of 2, at least 2.

Ports:
- clka  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request valid.
- o_req_ready  output  1  request accepted when valid and ready are both high at a rising edge.
- i_req_we  input  1  1 = write, 0 = read.
- i_req_addr  input  ADDR_WIDTH  request address.
- i_req_din  input  DATA_WIDTH  write data.
- o_ena  output  1  RAM port enable.
- o_wea  output  1  RAM write enable.
- o_addra  output  ADDR_WIDTH  RAM address.
- o_dina  output  DATA_WIDTH  RAM write data.
- i_douta  input  DATA_WIDTH  RAM read data.
- o_rsp_valid  output  1  response data valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_data  output  DATA_WIDTH  response data (FIFO head).
- o_outstanding  output  $clog2(FIFO_DEPTH)+1  in-flight reads plus FIFO occupancy.

Behaviour:
- Clock and reset: single clock clka; reset i_rst_n is asynchronous, active-low.
- Reset state (i_rst_n = 0):
  - Tag pipe cleared; FIFO pointers and count set to 0; credits = FIFO_DEPTH.
  - o_rsp_valid = 0; o_outstanding = 0; o_rsp_data = 0.
  - o_ena, o_wea and o_req_ready are forced to 0 while i_rst_n is low.
- Accept:
  - acc = i_req_valid & o_req_ready.
  - o_req_ready = i_req_we ? 1 : (credits != 0). Writes never consume credits.
- RAM drive is combinational from the request:
  - o_ena = acc; o_wea = acc & i_req_we.
  - o_addra = i_req_addr; o_dina = i_req_din.
  - RAM samples at the same edge (edge N).
- Tag pipe:
  - RD_LATENCY-bit shift register; bit 0 is loaded with acc & ~i_req_we each edge.
  - The tail bit set at edge N+RD_LATENCY-1 means i_douta is valid and is pushed into the FIFO at edge N+RD_LATENCY.
  - Push data = i_douta sampled at that edge.
- Response FIFO:
  - Circular buffer; wr_ptr and rd_ptr wrap modulo FIFO_DEPTH; count register.
  - o_rsp_valid = (count != 0); o_rsp_data = mem[rd_ptr].
  - Pop = o_rsp_valid & i_rsp_ready.
  - A push to an empty FIFO becomes visible the cycle after the push edge; there is no combinational bypass.
- Latency: a read accepted at edge N gives o_rsp_valid = 1 in the cycle after edge N+RD_LATENCY.
- Credits:
  - Decrement on read accept; increment on pop. Simultaneous read accept and pop leaves credits unchanged.
  - Invariant: in-flight reads + count + credits == FIFO_DEPTH.
  - o_outstanding = FIFO_DEPTH - credits.
  - FIFO overflow is therefore impossible; an assertion flags push while count == FIFO_DEPTH.
- Boundaries:
  - credits == 0: reads stall (o_req_ready = 0) while writes still pass.
  - Full FIFO with i_rsp_ready = 0: o_rsp_data held stable.
  - Pointer wrap from FIFO_DEPTH-1 to 0 is seamless.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged.
  - Simultaneous push and pop on an empty FIFO is impossible, since pop requires valid.
- Ordering: responses return strictly in read-issue order; writes do not generate responses.
- Reset mid-operation: all in-flight tags and buffered data are discarded; RAM contents are untouched. After deassertion the block accepts on the first edge.

Decomposition:
- Shared package pkg_2 holds DATA_WIDTH, MEM_DEPTH, ADDR_WIDTH, RD_LATENCYA and a FIFO_DEPTH constant.
- The top-level instantiates this block with RD_LATENCY = RD_LATENCYA.
- One sub-module: latency_rsp_fifo, a parameterised synchronous FIFO with push/pop/count/head outputs and asynchronous active-low reset.
- Tag pipe and credit counter stay in latency_rd_resp.

Test Plan:
- Write then read:
  - Stimulus: RD_LATENCY = 2; write addr 3 data 0xA5 at edge 1, read addr 3 at edge 2.
  - Required: o_ena/o_wea pulse correctly; o_rsp_valid rises after edge 4 with o_rsp_data = 0xA5.
- Credit exhaustion:
  - Stimulus: FIFO_DEPTH = 4, i_rsp_ready = 0; issue 6 back-to-back reads.
  - Required: first 4 accepted; o_req_ready = 0 for reads thereafter; o_outstanding = 4. A write issued during the stall is accepted.
- Drain and reissue:
  - Stimulus: from the credit-exhaustion state, raise i_rsp_ready for 1 cycle.
  - Required: one pop; credits = 1; the next read is accepted the same cycle it is presented.
- Streaming with wrap:
  - Stimulus: i_rsp_ready = 1; 10 consecutive reads of addresses 0..9 pre-loaded with data 0x10+addr.
  - Required: 10 responses, in order, 0x10..0x19, with no bubbles after the first.
- Simultaneous accept and pop:
  - Stimulus: read accept and pop at the same edge.
  - Required: credits and o_outstanding unchanged.
- Reset mid-flight:
  - Stimulus: assert i_rst_n = 0 for 1 cycle with 2 reads in flight and 1 buffered.
  - Required: o_rsp_valid = 0 and o_outstanding = 0 immediately; no stale response appears later; a subsequent read returns correct data.

Source files
------------

// File: rtl/latency_rd_resp_pkg.sv
// Shared constants for the latency RAM port-A request/response front end.
package latency_rd_resp_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int MEM_DEPTH   = 16;
    localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH);
    localparam int RD_LATENCYA = 2;
    localparam int FIFO_DEPTH  = 4;

    // Width able to hold 0..depth inclusive (credits, occupancy).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/latency_rd_resp_if.sv
// Request and response handshake bundle between a requester and latency_rd_resp.
interface latency_rd_resp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_din;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_din, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_din, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/latency_rd_resp_fifo.sv
// Synchronous circular-buffer FIFO; head is registered storage, no bypass.
module latency_rsp_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    assign head = mem[rd_ptr];

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: rtl/latency_rd_resp.sv
// Port-A front end for the latency RAM: drives the RAM from valid/ready requests,
// tracks reads through a tag pipe and buffers returning data under credit control.
module latency_rd_resp
    import latency_rd_resp_pkg::*;
#(
    parameter int DATA_WIDTH = latency_rd_resp_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH  = latency_rd_resp_pkg::MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int RD_LATENCY = RD_LATENCYA,
    parameter int FIFO_DEPTH = latency_rd_resp_pkg::FIFO_DEPTH,
    parameter int CW         = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clka,
    input  logic                  i_rst_n,
    latency_rd_resp_if.slave      bus,
    output logic                  o_ena,
    output logic                  o_wea,
    output logic [ADDR_WIDTH-1:0] o_addra,
    output logic [DATA_WIDTH-1:0] o_dina,
    input  logic [DATA_WIDTH-1:0] i_douta,
    output logic [CW-1:0]         o_outstanding
);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic                  acc;
    logic                  rd_acc;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         credits;
    logic [CW-1:0]         fifo_count;
    logic [RD_LATENCY-1:0] tag_pipe;

    // Writes bypass credit accounting; everything is held off during reset.
    assign bus.req_ready = i_rst_n & (bus.req_we | (credits != '0));
    assign acc           = bus.req_valid & bus.req_ready;
    assign rd_acc        = acc & ~bus.req_we;

    assign o_ena   = acc;
    assign o_wea   = acc & bus.req_we;
    assign o_addra = bus.req_addr;
    assign o_dina  = bus.req_din;

    // Tail bit marks the edge at which i_douta carries the read's data.
    always_ff @(posedge clka or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= rd_acc;
            for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign push = tag_pipe[RD_LATENCY-1];

    // One credit per FIFO slot: taken at read accept, returned at pop.
    always_ff @(posedge clka or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits <= DEPTH_C;
        end else begin
            case ({rd_acc, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    assign o_outstanding = DEPTH_C - credits;
    assign bus.rsp_valid = (fifo_count != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    latency_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CW         (CW)
    ) u_rsp_fifo (
        .clk       (clka),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (i_douta),
        .pop       (pop),
        .head      (bus.rsp_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_latency_rd_resp.sv
// Directed bench for latency_rd_resp with a small latency-RAM model and a response scoreboard.
module tb_latency_rd_resp;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RL = 2;
    localparam int FD = 4;
    localparam int CW = 3;

    logic          clka = 1'b0;
    logic          rst_n;
    logic          o_ena, o_wea;
    logic [AW-1:0] o_addra;
    logic [DW-1:0] o_dina;
    logic [DW-1:0] i_douta;
    logic [CW-1:0] o_outstanding;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];

    latency_rd_resp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    latency_rd_resp #(
        .DATA_WIDTH(DW), .MEM_DEPTH(16), .RD_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clka          (clka),
        .i_rst_n       (rst_n),
        .bus           (bus),
        .o_ena         (o_ena),
        .o_wea         (o_wea),
        .o_addra       (o_addra),
        .o_dina        (o_dina),
        .i_douta       (i_douta),
        .o_outstanding (o_outstanding)
    );

    always #5 clka = ~clka;

    // Latency RAM model: data read at edge N is on i_douta after edge N+RL-1.
    logic [DW-1:0] ram     [16];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clka) begin
        if (o_ena && o_wea) ram[o_addra] <= o_dina;
        rd_pipe[0] <= ram[o_addra];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_douta = rd_pipe[RL-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each accepted response is compared against the scoreboard head.
    always @(negedge clka) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got 0x%0h expected none", bus.rsp_data);
            end else begin
                check("rsp_data", 32'(bus.rsp_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic set_req(input logic we, input int addr, input int din);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = AW'(addr);
        bus.req_din   = DW'(din);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clka);
            if (o_outstanding == '0 && sb.size() == 0) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_addr  = '0;
        bus.req_din   = '0;
        set_req(1'b1, 0, 0);

        // Reset state, with a request presented
        @(negedge clka);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_ena", 32'(o_ena), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_outstanding", 32'(o_outstanding), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        cyc();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;

        // Write 0xA5 to addr 3, then read it back
        set_req(1'b1, 3, 8'hA5);
        @(negedge clka);
        check("wr_ena", 32'(o_ena), 1);
        check("wr_wea", 32'(o_wea), 1);
        cyc();
        set_req(1'b0, 3, 0);
        sb.push_back(8'hA5);
        @(negedge clka);
        check("rd_ena", 32'(o_ena), 1);
        check("rd_wea", 32'(o_wea), 0);
        cyc();
        idle();
        @(negedge clka);
        check("lat_n1_valid", 32'(bus.rsp_valid), 0);
        cyc();
        @(negedge clka);
        check("lat_n2_valid", 32'(bus.rsp_valid), 0);
        cyc();
        @(negedge clka);
        check("lat_n3_valid", 32'(bus.rsp_valid), 1);
        cyc();

        // Preload 0..9 with 0x10+addr, addr 12 with 0x5C
        for (int a = 0; a < 10; a++) begin
            set_req(1'b1, a, 8'h10 + a);
            cyc();
        end
        set_req(1'b1, 12, 8'h5C);
        cyc();
        idle();

        // Streaming reads 0..9 with a free-running consumer
        fork
            begin
                for (int a = 0; a < 10; a++) begin
                    set_req(1'b0, a, 0);
                    sb.push_back(8'h10 + a);
                    @(negedge clka);
                    check("stream_req_ready", 32'(bus.req_ready), 1);
                    cyc();
                end
                idle();
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clka);
                    if (bus.rsp_valid) seen = 1'b1;
                end
                check("stream_first_valid", 32'(seen), 1);
                for (int i = 1; i < 10; i++) begin
                    @(negedge clka);
                    check("stream_no_bubble", 32'(bus.rsp_valid), 1);
                end
            end
        join
        wait_drain("stream_drain", 20);
        cyc();

        // Credit exhaustion: six reads, consumer stalled
        bus.rsp_ready = 1'b0;
        for (int a = 0; a < 6; a++) begin
            set_req(1'b0, a, 0);
            @(negedge clka);
            check("exh_req_ready", 32'(bus.req_ready), (a < 4) ? 32'd1 : 32'd0);
            if (a < 4) sb.push_back(8'h10 + a);
            cyc();
        end
        set_req(1'b1, 13, 8'h6D);
        @(negedge clka);
        check("exh_outstanding", 32'(o_outstanding), 4);
        check("exh_wr_ready", 32'(bus.req_ready), 1);
        check("exh_wr_wea", 32'(o_wea), 1);
        cyc();
        idle();
        cyc();
        cyc();
        @(negedge clka);
        check("full_rsp_valid", 32'(bus.rsp_valid), 1);
        check("full_hold_data", 32'(bus.rsp_data), 8'h10);
        check("full_outstanding", 32'(o_outstanding), 4);
        cyc();

        // Drain one then reissue a read
        set_req(1'b0, 12, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clka);
        check("drain_stall", 32'(bus.req_ready), 0);
        cyc();
        bus.rsp_ready = 1'b0;
        @(negedge clka);
        check("drain_req_ready", 32'(bus.req_ready), 1);
        check("drain_outstanding", 32'(o_outstanding), 3);
        sb.push_back(8'h5C);
        cyc();
        idle();
        @(negedge clka);
        check("reissue_outstanding", 32'(o_outstanding), 4);
        cyc();

        // Simultaneous read accept and pop
        bus.rsp_ready = 1'b1;
        cyc();
        set_req(1'b0, 5, 0);
        @(negedge clka);
        check("sim_pre_outstanding", 32'(o_outstanding), 3);
        check("sim_req_ready", 32'(bus.req_ready), 1);
        check("sim_rsp_valid", 32'(bus.rsp_valid), 1);
        sb.push_back(8'h15);
        cyc();
        idle();
        bus.rsp_ready = 1'b0;
        @(negedge clka);
        check("sim_post_outstanding", 32'(o_outstanding), 3);
        cyc();
        bus.rsp_ready = 1'b1;
        wait_drain("sim_drain", 20);
        cyc();

        // Reset with one buffered read and two in flight
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 0, 0);
        cyc();
        idle();
        cyc();
        set_req(1'b0, 1, 0);
        cyc();
        set_req(1'b0, 2, 0);
        cyc();
        idle();
        @(negedge clka);
        check("pre_rst_outstanding", 32'(o_outstanding), 3);
        check("pre_rst_valid", 32'(bus.rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("midrst_outstanding", 32'(o_outstanding), 0);
        cyc();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clka);
            check("no_stale_rsp", 32'(bus.rsp_valid), 0);
        end
        cyc();
        set_req(1'b0, 12, 0);
        sb.push_back(8'h5C);
        @(negedge clka);
        check("post_rst_req_ready", 32'(bus.req_ready), 1);
        cyc();
        idle();
        wait_drain("post_rst_drain", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
